// File: rtl/keypad_pkg.sv
// Shared keypad types: debounce FSM states, key code type and reset value.
// Imported by the keypad scanner back-end blocks.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } kd_state_t;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_RESET = 4'h0;

endpackage

// File: rtl/key_debounce_history.sv
// Debounces scanner key presses and releases with a cycle counter.
// Keeps a two-deep history of accepted keys and holds the scanner row.
module key_debounce_history
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      key_valid,
    input  key_code_t key_code,
    output logic      scan_hold,
    output logic      press_pulse,
    output key_code_t key_new,
    output key_code_t key_old
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    kd_state_t     state;
    logic [CW-1:0] cnt;
    key_code_t     cand;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= KEY_RESET;
            scan_hold   <= 1'b0;
            press_pulse <= 1'b0;
            key_new     <= KEY_RESET;
            key_old     <= KEY_RESET;
        end else begin
            press_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        cand      <= key_code;
                        cnt       <= '0;
                        state     <= PRESS;
                        scan_hold <= 1'b1;
                    end
                end
                PRESS: begin
                    // A dropout or a code change restarts qualification.
                    if (!key_valid || key_code != cand) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        scan_hold <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        cnt         <= '0;
                        state       <= HELD;
                        key_old     <= key_new;
                        key_new     <= cand;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!key_valid) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (key_valid) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        scan_hold <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt       <= '0;
                    state     <= IDLE;
                    scan_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce_history.sv
// Bench for key_debounce_history with DEBOUNCE_CYCLES=4.
// Run-length reference model checked every cycle plus literal pins.
module tb_key_debounce_history;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       scan_hold;
    logic       press_pulse;
    logic [3:0] key_new;
    logic [3:0] key_old;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    bit en = 1'b0;

    key_debounce_history #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .scan_hold  (scan_hold),
        .press_pulse(press_pulse),
        .key_new    (key_new),
        .key_old    (key_old)
    );

    always #5 clk = ~clk;

    // Model: mode 0 waiting, 1 qualifying, 2 held, 3 releasing;
    // run = consecutive qualifying samples seen, entry sample included.
    int         m_mode = 0;
    int         m_run = 0;
    logic [3:0] m_cand = 4'h0;
    logic [3:0] m_new = 4'h0;
    logic [3:0] m_old = 4'h0;
    bit         m_pulse = 1'b0;

    always @(posedge clk) begin
        m_pulse = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_run  = 0;
            m_cand = 4'h0;
            m_new  = 4'h0;
            m_old  = 4'h0;
        end else begin
            case (m_mode)
                0: if (key_valid) begin
                    m_cand = key_code;
                    m_run  = 1;
                    m_mode = 1;
                end
                1: if (key_valid && key_code == m_cand) begin
                    m_run = m_run + 1;
                    if (m_run == N + 1) begin
                        m_old   = m_new;
                        m_new   = m_cand;
                        m_pulse = 1'b1;
                        m_mode  = 2;
                    end
                end else begin
                    m_mode = 0;
                end
                2: if (!key_valid) begin
                    m_run  = 1;
                    m_mode = 3;
                end
                default: if (key_valid) begin
                    m_mode = 2;
                end else begin
                    m_run = m_run + 1;
                    if (m_run == N + 1) m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (en) begin
            checks++;
            if (scan_hold !== (m_mode != 0) || press_pulse !== m_pulse ||
                key_new !== m_new || key_old !== m_old) begin
                failures++;
                $display("FAIL cycle t=%0t act hold=%b pulse=%b new=%h old=%h req hold=%b pulse=%b new=%h old=%h",
                         $time, scan_hold, press_pulse, key_new, key_old,
                         (m_mode != 0), m_pulse, m_new, m_old);
            end
            if (press_pulse === 1'b1) pulses++;
        end
    end

    task automatic drive(input logic kv, input logic [3:0] kc, input int n);
        key_valid = kv;
        key_code  = kc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 4'h0, 2);
        en = 1'b1;
        check("reset_hold", scan_hold, 0);
        check("reset_new", key_new, 0);
        reset = 1'b0;

        // Reset with the counter at 2 inside PRESS.
        drive(1, 4'h2, 3);
        check("midpress_hold", scan_hold, 1);
        reset = 1'b1;
        drive(1, 4'h2, 1);
        reset = 1'b0;
        check("rst_hold", scan_hold, 0);
        check("rst_pulse", press_pulse, 0);
        check("rst_new", key_new, 0);
        check("rst_old", key_old, 0);
        drive(0, 4'h0, 2);

        // Clean press of 7: edge 0 raises hold, edge 4 accepts.
        drive(1, 4'h7, 1);
        check("p7_hold_e0", scan_hold, 1);
        check("p7_nopulse_e0", press_pulse, 0);
        drive(1, 4'h7, 3);
        check("p7_nopulse_e3", press_pulse, 0);
        drive(1, 4'h7, 1);
        check("p7_pulse", press_pulse, 1);
        check("p7_new", key_new, 7);
        check("p7_old", key_old, 0);
        drive(1, 4'h7, 1);
        check("p7_pulse_once", press_pulse, 0);
        drive(0, 4'h0, 4);
        check("p7_rel_e3", scan_hold, 1);
        drive(0, 4'h0, 1);
        check("p7_rel_idle", scan_hold, 0);

        // Press bounce toggling every cycle.
        for (int i = 0; i < 10; i++) drive((i % 2) == 0, 4'h7, 1);
        drive(0, 4'h0, 2);
        check("bounce_pulses", pulses, 1);
        check("bounce_new", key_new, 7);

        // Code change mid-qualification, then 0xA steady.
        drive(1, 4'h3, 2);
        drive(1, 4'hA, 1);
        check("chg_rejected", scan_hold, 0);
        drive(1, 4'hA, 5);
        check("chg_pulse", press_pulse, 1);
        check("chg_new", key_new, 4'hA);
        check("chg_old", key_old, 7);
        drive(0, 4'h0, 6);

        // Held 5, release bounce, then full release and a press of C.
        drive(1, 4'h5, 5);
        check("p5_new", key_new, 5);
        drive(0, 4'h0, 2);
        drive(1, 4'h5, 1);
        drive(0, 4'h0, 5);
        check("relb_idle", scan_hold, 0);
        check("relb_pulses", pulses, 3);
        drive(1, 4'hC, 5);
        check("pC_new", key_new, 4'hC);
        check("pC_old", key_old, 5);
        drive(0, 4'h0, 5);

        // Second key while held.
        drive(1, 4'h1, 5);
        drive(1, 4'h9, 4);
        check("k2_new", key_new, 1);
        check("k2_old", key_old, 4'hC);
        drive(0, 4'h0, 5);
        check("k2_pulses", pulses, 5);

        // Same key twice shifts history.
        drive(1, 4'h1, 5);
        check("rep_new", key_new, 1);
        check("rep_old", key_old, 1);
        drive(0, 4'h0, 5);

        // One sample short of qualification is not accepted.
        drive(1, 4'h6, 4);
        drive(0, 4'h0, 2);
        check("short_new", key_new, 1);
        check("short_pulses", pulses, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce_history.md
# key_debounce_history

Downstream of the keypad row/column scanner. Takes the scanner's raw key-present flag and 4-bit hex key code, debounces press and release with a cycle counter, and accepts exactly one key per physical press. It keeps a two-deep history of accepted keys for the dual seven-segment display driver. It also asserts a hold back to the scanner so the scanner stops cycling rows while a key is being qualified or held.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 240000 (10 ms at 24 MHz): stable sampled cycles required for a press or a release; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  scanner reports a key present (any column active on the driven row).
- key_code  input  4  scanner's hex code for that key (0x0–0xF); meaningful only when key_valid=1.
- scan_hold  output  1  1 = scanner must freeze on its current row.
- press_pulse  output  1  single-cycle strobe: a new key was accepted.
- key_new  output  4  most recently accepted key.
- key_old  output  4  key accepted before key_new.

## Operation
- All outputs are registered. Reset values: scan_hold=0, press_pulse=0, key_new=0x0, key_old=0x0, state IDLE, counter=0, candidate=0x0.
- Counter width is $clog2(DEBOUNCE_CYCLES). It never wraps: it is cleared on every state entry and compared against DEBOUNCE_CYCLES-1 before incrementing.
- IDLE (scan_hold=0):
  - key_valid=1 → capture key_code into candidate, clear counter, go to PRESS.
- PRESS (scan_hold=1):
  - key_valid=0, or key_code≠candidate → IDLE, counter cleared, nothing accepted (bounce rejected).
  - Otherwise, if counter==DEBOUNCE_CYCLES-1 → go to HELD, key_old←key_new, key_new←candidate, press_pulse←1.
  - Otherwise counter++.
- HELD (scan_hold=1):
  - key_valid=0 → clear counter, go to RELEASE.
  - key_valid=1 with any code, including a second key → stay in HELD. No history change.
- RELEASE (scan_hold=1):
  - key_valid=1 → HELD, counter cleared (release bounce).
  - Else, if counter==DEBOUNCE_CYCLES-1 → IDLE.
  - Else counter++.
- press_pulse is 1 only in the cycle immediately after the accepting edge and 0 in all other cycles.
- Repeated presses of the same key each shift history (e.g. key 5 twice → key_new=5, key_old=5).
- Reset asserted in any state, mid-count included, forces all reset values on that edge. Reset has priority over every transition.

## Timing
- Press latency: key_valid sampled high with a constant code on edges 0..N (N=DEBOUNCE_CYCLES), i.e. N+1 consecutive edges. Edge 0 enters PRESS. Edge N updates key_new/key_old and raises press_pulse.
- scan_hold rises on the edge that leaves IDLE, so the scanner sees the hold one cycle after the key_valid sample. The scanner must tolerate that single extra cycle.
- Release latency: key_valid sampled low on N+1 consecutive edges. Edge 0 enters RELEASE. Edge N enters IDLE, and scan_hold falls at that edge.
- A one-cycle key_valid glitch in IDLE produces PRESS→IDLE in two cycles, with scan_hold high for exactly one cycle and no press_pulse.
- Throughput: at most one accepted key per 2N+2 cycles.

## Structure
- Shared package keypad_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} kd_state_t
  - typedef logic [3:0] key_code_t, used for key_code, key_new, key_old and the scanner's code output
  - localparam KEY_RESET = 4'h0
- Single module, no sub-module. The counter and the two-entry history are inline registers.

## Test plan
Bench runs with DEBOUNCE_CYCLES=4.
- Reset mid-PRESS (counter=2): reset for 1 cycle → scan_hold=0, press_pulse=0, key_new=0, key_old=0; next clean press is accepted normally.
- Clean press: key_valid=1, code 0x7 held 5 edges → press_pulse high exactly one cycle after edge 4, key_new=7, key_old=0; scan_hold=1 from edge 0.
- Bounce on press: key_valid 1,0,1 toggling every cycle for 10 cycles → no press_pulse, history unchanged, state returns to IDLE each time.
- Code change during PRESS: 0x3 for 2 edges, then 0xA steady → the 0x3 attempt is rejected; after IDLE recapture, 0xA is accepted 5 edges later, giving key_new=A.
- Held plus release bounce: hold 0x5 until accepted, drop key_valid for 2 cycles, reassert, drop for 5 cycles → exactly one press_pulse; a subsequent 0xC press gives key_new=C, key_old=5.
- Second key while HELD: hold 0x1 accepted, then present 0x9 while still valid → no pulse, key_new remains 1.
